// File: rtl/pixel_frame_writer.sv
// Raster-order frame memory writer: measures width/height, flags line-length errors.
// Optional FRAME_WRITER_RGB_SWAP_EN reverses byte order of each pixel (BGR -> RGB).
module pixel_frame_writer #(
  parameter int MAX_W  = 512,
  parameter int MAX_H  = 512,
  parameter int ADDR_W = 18,
  parameter int DIM_W  = 10
) (
  input  logic              Clk_in,
  input  logic              Rst_in,
  input  logic              pixel_ready,
  input  logic              pixel_valid,
  input  logic              line_end,
  input  logic [23:0]       pixel_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  output logic [DIM_W-1:0]  img_width,
  output logic [DIM_W-1:0]  img_height,
  output logic              frame_done,
  output logic              err_line,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FIRST_LINE, LINES} state_t;

  state_t            state_reg, state_next;
  logic [DIM_W-1:0]  col_reg, col_next, row_reg, row_next;
  logic [DIM_W-1:0]  width_reg, width_next, height_reg, height_next;
  logic [ADDR_W-1:0] base_reg, base_next, addr_reg, addr_next;
  logic [23:0]       wdata_reg, wdata_next, pixel_out;
  logic              ready_q_reg, we_reg, we_next, done_reg, done_next;
  logic              err_reg, err_next, busy_reg;

  logic              start, cur_first, overflow, accept;
  logic [DIM_W-1:0]  cur_col, cur_row, col_after;
  logic [ADDR_W-1:0] cur_base;

`ifdef FRAME_WRITER_RGB_SWAP_EN
  for (genvar gi = 0; gi < 3; gi++) begin : g_swap
    assign pixel_out[gi*8 +: 8] = pixel_data[(2-gi)*8 +: 8];
  end
`else
  assign pixel_out = pixel_data;
`endif

  // The frame-start cycle behaves as a FIRST_LINE cycle with all counters cleared.
  assign start     = (state_reg == IDLE) && pixel_ready && !ready_q_reg;
  assign cur_first = start || (state_reg == FIRST_LINE);
  assign cur_col   = start ? '0 : col_reg;
  assign cur_row   = start ? '0 : row_reg;
  assign cur_base  = start ? '0 : base_reg;
  assign overflow  = pixel_valid && ((cur_col == DIM_W'(MAX_W)) ||
                     ((cur_col == '0) && (cur_row == DIM_W'(MAX_H))));
  assign accept    = pixel_valid && !overflow;
  assign col_after = cur_col + DIM_W'(accept);

  always_comb begin
    state_next  = state_reg;
    col_next    = col_reg;
    row_next    = row_reg;
    base_next   = base_reg;
    width_next  = width_reg;
    height_next = height_reg;
    err_next    = err_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    we_next     = 1'b0;
    done_next   = 1'b0;
    if (start) begin
      width_next  = '0;
      height_next = '0;
      err_next    = 1'b0;
      state_next  = FIRST_LINE;
    end
    if ((state_reg != IDLE) && !pixel_ready) begin
      // An unterminated partial line still counts as a line.
      height_next = row_reg + DIM_W'(col_reg != '0);
      if ((state_reg == FIRST_LINE) && (col_reg != '0))
        width_next = col_reg;
      done_next  = 1'b1;
      state_next = IDLE;
    end else if (start || (state_reg != IDLE)) begin
      if (overflow)
        err_next = 1'b1;
      if (accept) begin
        we_next    = 1'b1;
        addr_next  = cur_base + ADDR_W'(cur_col);
        wdata_next = pixel_out;
      end
      col_next  = col_after;
      row_next  = cur_row;
      base_next = cur_base;
      if (line_end && (col_after != '0)) begin
        col_next = '0;
        row_next = cur_row + DIM_W'(1);
        if (cur_first) begin
          width_next = col_after;
          base_next  = ADDR_W'(col_after);
          state_next = LINES;
        end else begin
          if (col_after != width_reg)
            err_next = 1'b1;
          base_next = cur_base + ADDR_W'(width_reg);
        end
      end
    end
  end

  always_ff @(posedge Clk_in or posedge Rst_in) begin
    if (Rst_in) begin
      state_reg   <= IDLE;
      col_reg     <= '0;
      row_reg     <= '0;
      base_reg    <= '0;
      width_reg   <= '0;
      height_reg  <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      ready_q_reg <= 1'b0;
      we_reg      <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      col_reg     <= col_next;
      row_reg     <= row_next;
      base_reg    <= base_next;
      width_reg   <= width_next;
      height_reg  <= height_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      ready_q_reg <= pixel_ready;
      we_reg      <= we_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      busy_reg    <= (state_next != IDLE);
    end
  end

  assign mem_we     = we_reg;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign img_width  = width_reg;
  assign img_height = height_reg;
  assign frame_done = done_reg;
  assign err_line   = err_reg;
  assign busy       = busy_reg;

endmodule
